// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared feeder constants, state enum and element type; beat count follows SKEW_EN
package mpu_pkg;

  localparam int DIM        = 8;
  localparam int ELEM_BITS  = 8;
  localparam int CHUNK_BITS = DIM * DIM * ELEM_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } feeder_state_e;

  typedef logic [ELEM_BITS-1:0] elem_t;

  // Skewed streams need dim-1 extra beats to drain the diagonal wavefront.
  function automatic int beats_per_chunk(input int d);
`ifdef SKEW_EN
    return 2 * d - 1;
`else
    return d;
`endif
  endfunction

endpackage

// File: rtl/skew_lane_select.sv
// rtl/skew_lane_select.sv - per-lane element mux; SKEW_EN delays lane i by i beats
module skew_lane_select
  import mpu_pkg::*;
#(
  parameter int num_bits  = CHUNK_BITS,
  parameter int elem_bits = ELEM_BITS,
  parameter int dim       = DIM,
  parameter int tw        = $clog2(2 * dim)
) (
  input  logic [num_bits-1:0]  chunk,
  input  logic [tw-1:0]        t,
  input  logic [tw-1:0]        lane,
  output logic [elem_bits-1:0] elem
);

  localparam int IW = $clog2(num_bits);

  int            row;
  logic [IW-1:0] idx;

  always_comb begin
`ifdef SKEW_EN
    row = int'(t) - int'(lane);
`else
    row = int'(t);
`endif
    idx  = '0;
    elem = '0;
    // Rows outside the matrix are the zero padding of the wavefront.
    if (row >= 0 && row < dim) begin
      idx  = IW'((row * dim + int'(lane)) * elem_bits);
      elem = chunk[idx +: elem_bits];
    end
  end

endmodule

// File: rtl/chunk_skew_feeder.sv
// rtl/chunk_skew_feeder.sv - captures a 512-bit chunk and streams it as row beats to the array
module chunk_skew_feeder
  import mpu_pkg::*;
#(
  parameter int num_bits  = CHUNK_BITS,
  parameter int elem_bits = ELEM_BITS,
  parameter int dim       = DIM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [num_bits-1:0]      chunk_in,
  input  logic                     chunk_valid,
  output logic                     chunk_ready,
  output logic [dim*elem_bits-1:0] row_out,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic                     row_last,
  output logic                     busy
);

  localparam int            TW     = $clog2(2 * dim);
  localparam int            NB     = beats_per_chunk(dim);
  localparam logic [TW-1:0] T_LAST = TW'(NB - 1);

  feeder_state_e            state, state_n;
  logic [TW-1:0]            t, t_n;
  logic [num_bits-1:0]      chunk_buf, buf_n;
  logic [dim*elem_bits-1:0] row_n;
  logic                     accept, xfer;

  // A new chunk may slip in on the final beat so back-to-back chunks leave no bubble.
  assign chunk_ready = !rst && ((state == IDLE) || (row_last && row_ready));
  assign accept      = chunk_valid && chunk_ready;
  assign xfer        = (state == FEED) && row_ready;

  always_comb begin
    state_n = state;
    t_n     = t;
    buf_n   = chunk_buf;
    if (accept) begin
      state_n = FEED;
      t_n     = '0;
      buf_n   = chunk_in;
    end else if (xfer) begin
      if (t == T_LAST) begin
        state_n = IDLE;
        t_n     = '0;
      end else begin
        t_n = t + TW'(1);
      end
    end
  end

  // Lanes look at next-cycle buffer and beat so row_out can be registered with no extra latency.
  for (genvar i = 0; i < dim; i++) begin : g_lane
    skew_lane_select #(
      .num_bits (num_bits),
      .elem_bits(elem_bits),
      .dim      (dim),
      .tw       (TW)
    ) u_sel (
      .chunk(buf_n),
      .t    (t_n),
      .lane (TW'(i)),
      .elem (row_n[i*elem_bits +: elem_bits])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      t         <= '0;
      chunk_buf <= '0;
      row_out   <= '0;
      row_valid <= 1'b0;
      row_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      t         <= t_n;
      chunk_buf <= buf_n;
      row_out   <= (state_n == FEED) ? row_n : '0;
      row_valid <= (state_n == FEED);
      row_last  <= (state_n == FEED) && (t_n == T_LAST);
      busy      <= (state_n == FEED);
    end
  end

endmodule

// File: tb/tb_chunk_skew_feeder.sv
// tb/tb_chunk_skew_feeder.sv - self-checking bench for chunk_skew_feeder; expectations follow SKEW_EN
module tb_chunk_skew_feeder;
  import mpu_pkg::*;

  localparam int NB = beats_per_chunk(DIM);
  localparam int RW = DIM * ELEM_BITS;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [CHUNK_BITS-1:0] chunk_in = '0;
  logic                  chunk_valid = 1'b0;
  logic                  chunk_ready;
  logic [RW-1:0]         row_out;
  logic                  row_valid;
  logic                  row_ready = 1'b1;
  logic                  row_last;
  logic                  busy;

  always #5 clk = ~clk;

  chunk_skew_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .chunk_in   (chunk_in),
    .chunk_valid(chunk_valid),
    .chunk_ready(chunk_ready),
    .row_out    (row_out),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_last   (row_last),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Matrix-level model: which chunk is held and which beat is on the output.
  logic  m_active = 1'b0;
  int    m_t = 0;
  elem_t m_mat [DIM][DIM];

  function automatic logic [RW-1:0] model_row();
    logic [RW-1:0] r;
    r = '0;
    if (m_active) begin
      for (int i = 0; i < DIM; i++) begin
`ifdef SKEW_EN
        int row = m_t - i;
`else
        int row = m_t;
`endif
        if (row >= 0 && row < DIM) r[i*ELEM_BITS +: ELEM_BITS] = m_mat[row][i];
      end
    end
    return r;
  endfunction

  function automatic logic model_ready();
    return !rst && (!m_active || (m_t == NB - 1 && row_ready));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_t      = 0;
    end else if (chunk_valid && model_ready()) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++)
          m_mat[r][c] = chunk_in[(r*DIM + c)*ELEM_BITS +: ELEM_BITS];
      m_active = 1'b1;
      m_t      = 0;
    end else if (m_active && row_ready) begin
      if (m_t == NB - 1) begin
        m_active = 1'b0;
        m_t      = 0;
      end else begin
        m_t++;
      end
    end
  end

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("row_out", 64'(row_out), 64'(model_row()));
      check("row_valid", 64'(row_valid), 64'(m_active));
      check("row_last", 64'(row_last), 64'(m_active && m_t == NB - 1));
      check("busy", 64'(busy), 64'(m_active));
      check("chunk_ready", 64'(chunk_ready), 64'(model_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [CHUNK_BITS-1:0] chunk_a, chunk_b;
  logic [63:0]           lit0, lit1, lit3, lit4, litl, litb0;
  int                    pulses;

  initial begin
    for (int k = 0; k < CHUNK_BITS / 8; k++) chunk_a[k*8 +: 8] = 8'(k + 1);
    chunk_b = {(CHUNK_BITS/8){8'hAA}};
`ifdef SKEW_EN
    lit0  = 64'h0000000000000001;
    lit1  = 64'h0000000000000209;
    lit3  = 64'h00000000040B1219;
    lit4  = 64'h000000050C131A21;
    litl  = 64'h4000000000000000;
    litb0 = 64'h00000000000000AA;
`else
    lit0  = 64'h0807060504030201;
    lit1  = 64'h100F0E0D0C0B0A09;
    lit3  = 64'h201F1E1D1C1B1A19;
    lit4  = 64'h2827262524232221;
    litl  = 64'h403F3E3D3C3B3A39;
    litb0 = 64'hAAAAAAAAAAAAAAAA;
`endif

    // Reset, then a single chunk with a 5-cycle stall on beat 3.
    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_chunk_ready", 64'(chunk_ready), 64'd1);
    check("reset_row_out", 64'(row_out), 64'd0);
    chunk_in    = chunk_a;
    chunk_valid = 1'b1;
    tick();
    chunk_valid = 1'b0;
    #1;
    check("a_beat0", 64'(row_out), lit0);
    for (int k = 1; k < NB; k++) begin
      tick();
      #1;
      if (k == 1) check("a_beat1", 64'(row_out), lit1);
      if (k == 3) begin
        check("a_beat3", 64'(row_out), lit3);
        row_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          #1;
          check("stall_hold", 64'(row_out), lit3);
        end
        row_ready = 1'b1;
      end
      if (k == 4) check("a_beat4_after_stall", 64'(row_out), lit4);
      if (k == NB - 1) begin
        check("a_last_beat", 64'(row_out), litl);
        check("a_last_flag", 64'(row_last), 64'd1);
      end
    end
    tick();
    #1;
    check("a_idle_valid", 64'(row_valid), 64'd0);
    check("a_idle_busy", 64'(busy), 64'd0);

    // Back-to-back: second chunk waiting while the first streams.
    chunk_in    = chunk_a;
    chunk_valid = 1'b1;
    tick();
    chunk_in = chunk_b;
    #1;
    pulses = 0;
    for (int k = 0; k < NB; k++) begin
      if (k > 0) begin
        tick();
        #1;
      end
      if (chunk_ready) pulses++;
      check("b2b_ready_window", 64'(chunk_ready), 64'(k == NB - 1));
    end
    tick();
    chunk_valid = 1'b0;
    #1;
    check("b2b_pulses", 64'(pulses), 64'd1);
    check("b2b_beat0", 64'(row_out), litb0);
    check("b2b_no_gap", 64'(row_valid), 64'd1);
    repeat (NB) tick();
    #1;
    check("b2b_idle", 64'(busy), 64'd0);

    // Reset at beat 7 with a chunk pending.
    chunk_in    = chunk_a;
    chunk_valid = 1'b1;
    tick();
    chunk_valid = 1'b0;
    repeat (7) tick();
    chunk_in    = chunk_b;
    chunk_valid = 1'b1;
    rst         = 1'b1;
    #1;
    check("rst_blocks_ready", 64'(chunk_ready), 64'd0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_valid", 64'(row_valid), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_row_out", 64'(row_out), 64'd0);
    check("post_rst_ready", 64'(chunk_ready), 64'd1);
    tick();
    chunk_valid = 1'b0;
    #1;
    check("post_rst_beat0", 64'(row_out), litb0);
    check("post_rst_beat0_valid", 64'(row_valid), 64'd1);
    repeat (NB + 2) tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
